seven_seg_scan_controller: RTL and testbench

Time-multiplexed display scanner that shares one `sevenSegmentDecoder` instance among `DIGITS` BCD digits. Each cycle it drives the decoder's `w,x,y,z` inputs with one digit's nibble and drives a one-hot common-enable to the matching display digit. It inserts blanking gaps between digits to prevent ghosting. New display values are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seven_seg_scan_controller.sv | 152 +++++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller
//   Time-multiplexed scanner for DIGITS BCD digits sharing one seven-segment
//   decoder. Each digit is shown for DWELL cycles, followed by BLANK dark
//   cycles to prevent ghosting. New values are double-buffered (shadow ->
//   active) and only take effect at a frame boundary.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   en         : scan enable; low forces IDLE on the next edge
//   load       : single-cycle strobe capturing data_in
//   data_in    : DIGITS BCD nibbles, digit i = data_in[4i+3:4i]
//   blank_mask : per-digit force-dark, sampled live
//   w,x,y,z    : decoder inputs of the digit being shown (w = MSB)
//   digit_sel  : one-hot active-high digit enable
//   frame_done : one-cycle pulse when digit 0 of the next frame is first shown
//   bcd_err    : sticky, set when an unmasked nibble > 9 is shown
module seven_seg_scan_controller #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 4,
  parameter int BLANK  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic                  w,
  output logic                  x,
  output logic                  y,
  output logic                  z,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done,
  output logic                  bcd_err
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(DIGITS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t                state, nxt_state;
  logic [IW-1:0]         idx, nxt_idx;
  logic [CW-1:0]         cnt, nxt_cnt;
  logic [4*DIGITS-1:0]   shadow, active, nxt_active;
  logic                  pending;
  logic                  advance, wrap, boundary;
  logic [3:0]            nxt_nib;

  // Next-state and next-buffer computation. Outputs are registered from
  // these values so they line up with the state entered on the same edge.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    advance   = 1'b0;
    wrap      = 1'b0;
    boundary  = 1'b0;
    if (!en) begin
      nxt_state = IDLE;
      nxt_idx   = '0;
      nxt_cnt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          nxt_state = SHOW;
          nxt_idx   = '0;
          nxt_cnt   = '0;
          boundary  = 1'b1;   // entry counts as a boundary but not a frame
        end
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            nxt_cnt = '0;
            if (BLANK > 0) nxt_state = GAP;
            else           advance   = 1'b1;
          end else begin
            nxt_cnt = cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == BLANK_LAST) begin
            nxt_cnt = '0;
            advance = 1'b1;
          end else begin
            nxt_cnt = cnt + CW'(1);
          end
        end
        default: nxt_state = IDLE;
      endcase
      if (advance) begin
        nxt_state = SHOW;
        if (idx == LAST_IDX) begin
          nxt_idx = '0;
          wrap    = 1'b1;
        end else begin
          nxt_idx = idx + IW'(1);
        end
      end
    end
    boundary = boundary | wrap;

    // A load in the boundary cycle bypasses the shadow so it is not lost
    // behind the older pending value.
    nxt_active = active;
    if (boundary) begin
      if (load)         nxt_active = data_in;
      else if (pending) nxt_active = shadow;
    end
    nxt_nib = nxt_active[{nxt_idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      {w, x, y, z} <= 4'b0000;
      digit_sel  <= '0;
      frame_done <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      state  <= nxt_state;
      idx    <= nxt_idx;
      cnt    <= nxt_cnt;
      active <= nxt_active;
      if (load) shadow <= data_in;
      if (boundary)  pending <= 1'b0;
      else if (load) pending <= 1'b1;
      frame_done <= wrap;
      if (nxt_state == SHOW) begin
        {w, x, y, z} <= nxt_nib;
        // Invalid nibbles are driven to the decoder but the digit stays dark.
        if (blank_mask[nxt_idx] || (nxt_nib > 4'd9)) digit_sel <= '0;
        else                                        digit_sel <= DIGITS'(1) << nxt_idx;
        if (!blank_mask[nxt_idx] && (nxt_nib > 4'd9)) bcd_err <= 1'b1;
      end else begin
        {w, x, y, z} <= 4'b0000;
        digit_sel    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
module tb_seven_seg_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  blank_mask = 4'h0;

  logic       w, x, y, z;
  logic [3:0] digit_sel;
  logic       frame_done, bcd_err;

  logic       wb, xb, yb, zb;
  logic [3:0] digit_sel_b;
  logic       frame_done_b, bcd_err_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seven_seg_scan_controller #(.DIGITS(4), .DWELL(4), .BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
    .blank_mask(blank_mask), .w(w), .x(x), .y(y), .z(z),
    .digit_sel(digit_sel), .frame_done(frame_done), .bcd_err(bcd_err)
  );

  seven_seg_scan_controller #(.DIGITS(4), .DWELL(1), .BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
    .blank_mask(blank_mask), .w(wb), .x(xb), .y(yb), .z(zb),
    .digit_sel(digit_sel_b), .frame_done(frame_done_b), .bcd_err(bcd_err_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected select for position p in a 20-cycle frame (4 digits x (4 + 1)).
  function automatic logic [3:0] exp_sel(int p);
    int q;
    q = p % 20;
    if ((q % 5) < 4) return 4'(1 << (q / 5));
    return 4'h0;
  endfunction

  function automatic logic [3:0] exp_nib(int p, logic [15:0] d);
    int q;
    q = p % 20;
    if ((q % 5) < 4) return d[4*(q/5) +: 4];
    return 4'h0;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; load = 1'b1; data_in = 16'h4321; blank_mask = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({digit_sel, w, x, y, z, frame_done, bcd_err} !== 10'h0) begin
        fails++;
        $display("FAIL reset_outputs cyc=%0d got sel=%b wxyz=%b fd=%b err=%b want all 0",
                 i, digit_sel, {w, x, y, z}, frame_done, bcd_err);
      end
    end
    // Load still high on the first running edge: start is a boundary, so it bypasses.
    rst_n = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) tick();
      tests++;
      if (digit_sel !== exp_sel(k) || {w, x, y, z} !== exp_nib(k, 16'h4321) ||
          frame_done !== (k > 0 && (k % 20) == 0)) begin
        fails++;
        $display("FAIL start_scan k=%0d got sel=%b wxyz=%h fd=%b want sel=%b wxyz=%h fd=%b",
                 k, digit_sel, {w, x, y, z}, frame_done, exp_sel(k), exp_nib(k, 16'h4321),
                 (k > 0 && (k % 20) == 0));
      end
    end
  endtask

  task automatic test_double_buffer;
    for (int i = 1; i <= 6; i++) tick();
    load = 1'b1; data_in = 16'h9876;
    tick();
    load = 1'b0;
    for (int p = 7; p <= 39; p++) begin
      if (p > 7) tick();
      tests++;
      if (digit_sel !== exp_sel(p) ||
          {w, x, y, z} !== exp_nib(p, (p < 20) ? 16'h4321 : 16'h9876) ||
          frame_done !== (p == 20)) begin
        fails++;
        $display("FAIL double_buffer p=%0d got sel=%b wxyz=%h fd=%b want sel=%b wxyz=%h fd=%b",
                 p, digit_sel, {w, x, y, z}, frame_done, exp_sel(p),
                 exp_nib(p, (p < 20) ? 16'h4321 : 16'h9876), (p == 20));
      end
    end
  endtask

  task automatic test_bypass;
    load = 1'b1; data_in = 16'h5555;
    tick();
    load = 1'b0;
    tests++;
    if (digit_sel !== 4'b0001 || {w, x, y, z} !== 4'h5 || frame_done !== 1'b1) begin
      fails++;
      $display("FAIL bypass_first got sel=%b wxyz=%h fd=%b want sel=0001 wxyz=5 fd=1",
               digit_sel, {w, x, y, z}, frame_done);
    end
    tests++;
    if (dut.pending !== 1'b0) begin
      fails++;
      $display("FAIL bypass_pending got %b want 0", dut.pending);
    end
    for (int p = 1; p <= 19; p++) begin
      tick();
      tests++;
      if (digit_sel !== exp_sel(p) || {w, x, y, z} !== exp_nib(p, 16'h5555) ||
          frame_done !== 1'b0 || dut.pending !== 1'b0) begin
        fails++;
        $display("FAIL bypass_frame p=%0d got sel=%b wxyz=%h fd=%b pend=%b want sel=%b wxyz=%h fd=0 pend=0",
                 p, digit_sel, {w, x, y, z}, frame_done, dut.pending, exp_sel(p),
                 exp_nib(p, 16'h5555));
      end
    end
  endtask

  task automatic test_invalid_mask;
    logic [3:0] es, en_nib;
    blank_mask = 4'b0001; load = 1'b1; data_in = 16'h0A00;
    tick();
    load = 1'b0;
    for (int p = 0; p <= 19; p++) begin
      if (p > 0) tick();
      es     = exp_sel(p);
      en_nib = exp_nib(p, 16'h0A00);
      if (blank_mask[p / 5] || en_nib > 4'd9) es = 4'h0;
      tests++;
      if (digit_sel !== es || {w, x, y, z} !== en_nib || bcd_err !== (p >= 10) ||
          frame_done !== (p == 0)) begin
        fails++;
        $display("FAIL invalid_mask p=%0d got sel=%b wxyz=%b err=%b fd=%b want sel=%b wxyz=%b err=%b fd=%b",
                 p, digit_sel, {w, x, y, z}, bcd_err, frame_done, es, en_nib, (p >= 10), (p == 0));
      end
    end
    // Valid data afterwards: error stays sticky, mask still darkens digit 0.
    load = 1'b1; data_in = 16'h4321;
    tick();
    load = 1'b0;
    tests++;
    if (digit_sel !== 4'b0000 || {w, x, y, z} !== 4'h1 || bcd_err !== 1'b1) begin
      fails++;
      $display("FAIL sticky_masked got sel=%b wxyz=%h err=%b want sel=0000 wxyz=1 err=1",
               digit_sel, {w, x, y, z}, bcd_err);
    end
    // Mask release mid-dwell is visible on the very next edge.
    blank_mask = 4'b0000;
    for (int p = 1; p <= 19; p++) begin
      tick();
      tests++;
      if (digit_sel !== exp_sel(p) || {w, x, y, z} !== exp_nib(p, 16'h4321) || bcd_err !== 1'b1) begin
        fails++;
        $display("FAIL sticky_unmask p=%0d got sel=%b wxyz=%h err=%b want sel=%b wxyz=%h err=1",
                 p, digit_sel, {w, x, y, z}, bcd_err, exp_sel(p), exp_nib(p, 16'h4321));
      end
    end
  endtask

  task automatic test_enable_reset;
    for (int i = 0; i <= 8; i++) tick();   // positions 0..8
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if ({digit_sel, w, x, y, z, frame_done} !== 9'h0) begin
        fails++;
        $display("FAIL en_drop cyc=%0d got sel=%b wxyz=%b fd=%b want all 0",
                 i, digit_sel, {w, x, y, z}, frame_done);
      end
    end
    en = 1'b1;
    tick();
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      tests++;
      if (digit_sel !== exp_sel(k) || {w, x, y, z} !== exp_nib(k, 16'h4321) ||
          frame_done !== (k == 20)) begin
        fails++;
        $display("FAIL en_restart k=%0d got sel=%b wxyz=%h fd=%b want sel=%b wxyz=%h fd=%b",
                 k, digit_sel, {w, x, y, z}, frame_done, exp_sel(k), exp_nib(k, 16'h4321), (k == 20));
      end
    end
    for (int i = 1; i <= 4; i++) tick();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if ({digit_sel, w, x, y, z, frame_done, bcd_err} !== 10'h0) begin
        fails++;
        $display("FAIL mid_reset cyc=%0d got sel=%b wxyz=%b fd=%b err=%b want all 0",
                 i, digit_sel, {w, x, y, z}, frame_done, bcd_err);
      end
    end
    rst_n = 1'b1;
    tick();
    for (int k = 0; k <= 19; k++) begin
      if (k > 0) tick();
      tests++;
      if (digit_sel !== exp_sel(k) || {w, x, y, z} !== 4'h0 || bcd_err !== 1'b0 ||
          frame_done !== 1'b0) begin
        fails++;
        $display("FAIL reset_restart k=%0d got sel=%b wxyz=%h err=%b fd=%b want sel=%b wxyz=0 err=0 fd=0",
                 k, digit_sel, {w, x, y, z}, bcd_err, frame_done, exp_sel(k));
      end
    end
  endtask

  task automatic test_blank0;
    rst_n = 1'b0;
    tick();
    tests++;
    if ({digit_sel_b, wb, xb, yb, zb, frame_done_b} !== 9'h0) begin
      fails++;
      $display("FAIL b0_reset got sel=%b wxyz=%b fd=%b want all 0",
               digit_sel_b, {wb, xb, yb, zb}, frame_done_b);
    end
    rst_n = 1'b1; en = 1'b1; load = 1'b1; data_in = 16'h4321;
    tick();
    load = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) tick();
      tests++;
      if (digit_sel_b !== 4'(1 << (k % 4)) || {wb, xb, yb, zb} !== 4'((k % 4) + 1) ||
          frame_done_b !== (k > 0 && (k % 4) == 0)) begin
        fails++;
        $display("FAIL b0_rotate k=%0d got sel=%b wxyz=%h fd=%b want sel=%b wxyz=%h fd=%b",
                 k, digit_sel_b, {wb, xb, yb, zb}, frame_done_b, 4'(1 << (k % 4)),
                 4'((k % 4) + 1), (k > 0 && (k % 4) == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_double_buffer();
    test_bypass();
    test_invalid_mask();
    test_enable_reset();
    test_blank0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
